// File: rtl/tl_ul_sram_responder.sv
// ---------------------------------------------------------------------------
// tl_ul_sram_responder
//
// TileLink-UL responder with a 64-bit data path in front of a small
// register-file memory. It accepts Get, PutFullData and PutPartialData on the
// A channel and answers with AccessAckData / AccessAck on the D channel.
// Requests are accepted one per cycle. Each response is held in a single
// registered stage.
//
// Parameters
//   BASE   byte base address of the memory window (aligned to DEPTH*8)
//   DEPTH  number of 64-bit words (power of 2, 2..256)
//
// Ports
//   clock, reset_n      clock (rising edge) and async active-low reset
//   a_valid/a_ready     A-channel handshake
//   a_opcode .. a_corrupt  A-channel request fields
//   d_valid/d_ready     D-channel handshake
//   d_opcode .. d_corrupt  D-channel response fields
// ---------------------------------------------------------------------------
module tl_ul_sram_responder #(
    parameter logic [31:0] BASE  = 32'h0800_0000,
    parameter int          DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [2:0]  a_size,
    input  logic [2:0]  a_source,
    input  logic [31:0] a_address,
    input  logic [7:0]  a_mask,
    input  logic [63:0] a_data,
    input  logic        a_corrupt,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [2:0]  d_size,
    output logic [2:0]  d_source,
    output logic        d_sink,
    output logic        d_denied,
    output logic [63:0] d_data,
    output logic        d_corrupt
);
    localparam int IW = $clog2(DEPTH);

    logic [63:0] mem [DEPTH];

    logic          a_fire;
    logic [IW-1:0] index;
    logic          hit;
    logic          is_get;
    logic          is_put;
    logic          align_ok;
    logic          denied;
    logic          wr_en;
    logic [7:0]    wr_be;
    logic [63:0]   rd_word;
    logic [63:0]   d_data_next;

    logic          d_valid_reg;
    logic [2:0]    d_opcode_reg;
    logic [2:0]    d_size_reg;
    logic [2:0]    d_source_reg;
    logic          d_denied_reg;
    logic [63:0]   d_data_reg;
    logic          d_corrupt_reg;

    // a_param carries no meaning for this responder.
    logic unused_param;
    assign unused_param = ^a_param;

    // Ready depends only on the response stage, never on a_valid.
    assign a_ready = !d_valid_reg || d_ready;
    assign a_fire  = a_valid && a_ready;

    assign index  = a_address[3 +: IW];
    assign hit    = (a_address[31:3+IW] == BASE[31:3+IW]);
    assign is_get = (a_opcode == 3'd4);
    assign is_put = (a_opcode == 3'd0) || (a_opcode == 3'd1);

    // Natural alignment to the transfer size; sizes above 3 are never aligned.
    always_comb begin
        align_ok = 1'b0;
        case (a_size)
            3'd0:    align_ok = 1'b1;
            3'd1:    align_ok = (a_address[0] == 1'b0);
            3'd2:    align_ok = (a_address[1:0] == 2'b00);
            3'd3:    align_ok = (a_address[2:0] == 3'b000);
            default: align_ok = 1'b0;
        endcase
    end

    assign denied = !(is_get || is_put) || !hit || (a_size > 3'd3) ||
                    !align_ok || (is_put && a_corrupt);

    // PutFull and PutPartial behave identically: the mask alone picks lanes.
    assign wr_en = a_fire && is_put && !denied;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane_be
            assign wr_be[gi] = wr_en && a_mask[gi];
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_be[i]) begin
                mem[index][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    // The read is captured into the response register, so a Put written at
    // one edge is seen by a Get firing at the following edge.
    assign rd_word     = mem[index];
    assign d_data_next = (is_get && !denied) ? rd_word : 64'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_valid_reg   <= 1'b0;
            d_opcode_reg  <= 3'd0;
            d_size_reg    <= 3'd0;
            d_source_reg  <= 3'd0;
            d_denied_reg  <= 1'b0;
            d_data_reg    <= 64'd0;
            d_corrupt_reg <= 1'b0;
        end else if (a_fire) begin
            // A new request always wins, even if D fires in the same cycle.
            d_valid_reg   <= 1'b1;
            d_opcode_reg  <= {2'b00, is_get};
            d_size_reg    <= a_size;
            d_source_reg  <= a_source;
            d_denied_reg  <= denied;
            d_data_reg    <= d_data_next;
            d_corrupt_reg <= denied && is_get;
        end else if (d_ready) begin
            d_valid_reg   <= 1'b0;
        end
    end

    assign d_valid   = d_valid_reg;
    assign d_opcode  = d_opcode_reg;
    assign d_param   = 2'b00;
    assign d_size    = d_size_reg;
    assign d_source  = d_source_reg;
    assign d_sink    = 1'b0;
    assign d_denied  = d_denied_reg;
    assign d_data    = d_data_reg;
    assign d_corrupt = d_corrupt_reg;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// ---------------------------------------------------------------------------
// Self-checking bench for tl_ul_sram_responder. A behavioural model computes
// each expected response directly from the protocol rules, using address
// arithmetic and a word array.
// ---------------------------------------------------------------------------
module tb_tl_ul_sram_responder;
    localparam logic [31:0] BASE  = 32'h0800_0000;
    localparam int          DEPTH = 16;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [2:0]  source;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
    } req_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [2:0]  source;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [2:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [2:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    int total = 0;
    int bad   = 0;

    logic [63:0] model_mem [DEPTH];

    always #5 clock = ~clock;

    tl_ul_sram_responder #(.BASE(BASE), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .a_corrupt(a_corrupt),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data),
        .d_corrupt(d_corrupt)
    );

    function automatic req_t mk_req(input logic [2:0] op, input logic [2:0] sz,
                                    input logic [2:0] src, input logic [31:0] addr,
                                    input logic [7:0] mask, input logic [63:0] data,
                                    input logic corr);
        req_t r;
        r = '{opcode: op, size: sz, source: src, addr: addr, mask: mask,
              data: data, corrupt: corr};
        return r;
    endfunction

    // Reference model: applies an accepted request and returns its response.
    function automatic rsp_t model_apply(input req_t r);
        rsp_t   s;
        bit     legal, is_get, is_put, hit, size_ok, aligned, denied;
        int     idx;
        legal   = (r.opcode == 0) || (r.opcode == 1) || (r.opcode == 4);
        is_get  = (r.opcode == 4);
        is_put  = (r.opcode == 0) || (r.opcode == 1);
        hit     = (r.addr >= BASE) && (r.addr < BASE + DEPTH * 8);
        size_ok = (r.size <= 3);
        aligned = size_ok && ((r.addr % (32'd1 << r.size)) == 0);
        denied  = !legal || !hit || !size_ok || !aligned || (is_put && r.corrupt);
        idx     = hit ? int'((r.addr - BASE) / 8) : 0;
        if (!denied && is_put) begin
            for (int i = 0; i < 8; i++) begin
                if (r.mask[i]) model_mem[idx][8*i +: 8] = r.data[8*i +: 8];
            end
        end
        s.opcode  = is_get ? 3'd1 : 3'd0;
        s.size    = r.size;
        s.source  = r.source;
        s.denied  = denied;
        s.data    = (!denied && is_get) ? model_mem[idx] : 64'd0;
        s.corrupt = denied && is_get;
        return s;
    endfunction

    task automatic drive_req(input req_t r);
        a_valid   = 1'b1;
        a_opcode  = r.opcode;
        a_size    = r.size;
        a_source  = r.source;
        a_address = r.addr;
        a_mask    = r.mask;
        a_data    = r.data;
        a_corrupt = r.corrupt;
        a_param   = 3'($urandom_range(0, 7));
    endtask

    // Presents one request, lets it fire on the next edge, returns at edge+1.
    task automatic issue(input req_t r);
        drive_req(r);
        @(posedge clock);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic test_reset;
        rsp_t obs;
        reset_n = 1'b0;
        d_ready = 1'b0;
        a_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        obs = {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
        total++;
        if (d_valid !== 1'b0 || a_ready !== 1'b1 || obs !== '0 ||
            d_param !== 2'b00 || d_sink !== 1'b0) begin
            bad++;
            $display("FAIL reset: got d_valid=%b a_ready=%b d=%h param=%b sink=%b, want 0/1/0/0/0",
                     d_valid, a_ready, obs, d_param, d_sink);
        end
        $display("txn reset: d_valid=%b a_ready=%b", d_valid, a_ready);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        d_ready = 1'b1;
    endtask

    task automatic test_fill;
        req_t r;
        rsp_t exp, obs;
        for (int i = 0; i < DEPTH; i++) begin
            r = mk_req(3'd0, 3'd3, 3'(i), BASE + 32'(i * 8), 8'hFF,
                       {$urandom, $urandom}, 1'b0);
            issue(r);
            exp = model_apply(r);
            obs = {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
            total++;
            if (d_valid !== 1'b1 || obs !== exp) begin
                bad++;
                $display("FAIL fill[%0d]: got v=%b %h want v=1 %h", i, d_valid, obs, exp);
            end
            $display("txn fill addr=%h src=%0d d_op=%0d den=%b", r.addr, r.source, d_opcode, d_denied);
        end
    endtask

    task automatic test_write_read;
        req_t r;
        rsp_t exp;
        r = mk_req(3'd0, 3'd3, 3'd5, BASE + 32'h10, 8'hFF, 64'h1122334455667788, 1'b0);
        issue(r);
        exp = model_apply(r);
        total++;
        if (d_valid !== 1'b1 || d_opcode !== 3'd0 || d_source !== 3'd5 || d_denied !== 1'b0) begin
            bad++;
            $display("FAIL putfull_ack: got v=%b op=%0d src=%0d den=%b want 1/0/5/0",
                     d_valid, d_opcode, d_source, d_denied);
        end
        $display("txn putfull addr=%h d_op=%0d den=%b", r.addr, d_opcode, d_denied);
        r = mk_req(3'd4, 3'd3, 3'd2, BASE + 32'h10, 8'h00, 64'd0, 1'b0);
        issue(r);
        exp = model_apply(r);
        total++;
        if (d_valid !== 1'b1 || d_opcode !== 3'd1 || d_data !== 64'h1122334455667788 ||
            d_denied !== 1'b0 || d_corrupt !== 1'b0 || d_size !== 3'd3 || d_source !== 3'd2) begin
            bad++;
            $display("FAIL get_after_put: got v=%b op=%0d data=%h den=%b cor=%b want 1/1/%h/0/0",
                     d_valid, d_opcode, d_data, d_denied, d_corrupt, exp.data);
        end
        $display("txn get addr=%h data=%h", r.addr, d_data);
    endtask

    task automatic test_partial;
        req_t r;
        rsp_t exp;
        r = mk_req(3'd1, 3'd3, 3'd1, BASE + 32'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0);
        issue(r);
        exp = model_apply(r);
        total++;
        if (d_opcode !== 3'd0 || d_denied !== 1'b0) begin
            bad++;
            $display("FAIL partial_ack: got op=%0d den=%b want 0/0", d_opcode, d_denied);
        end
        $display("txn putpartial addr=%h mask=%h", r.addr, r.mask);
        r = mk_req(3'd4, 3'd3, 3'd1, BASE + 32'h10, 8'hFF, 64'd0, 1'b0);
        issue(r);
        exp = model_apply(r);
        total++;
        if (d_data !== 64'h11223344_BBBBBBBB || d_opcode !== 3'd1) begin
            bad++;
            $display("FAIL partial_read: got data=%h op=%0d want 11223344bbbbbbbb/1", d_data, d_opcode);
        end
        $display("txn get addr=%h data=%h", r.addr, d_data);
    endtask

    task automatic test_denials;
        req_t        r;
        rsp_t        exp;
        req_t        tbl [4];
        logic [2:0]  want_op [4];
        logic        want_cor [4];
        tbl[0] = mk_req(3'd4, 3'd3, 3'd3, BASE + DEPTH * 8, 8'hFF, 64'd0, 1'b0);
        tbl[1] = mk_req(3'd2, 3'd3, 3'd4, BASE + 32'h10, 8'hFF, 64'hDEAD_BEEF_0000_1111, 1'b0);
        tbl[2] = mk_req(3'd0, 3'd3, 3'd6, BASE + 32'h4, 8'hFF, 64'hCAFE_CAFE_CAFE_CAFE, 1'b0);
        tbl[3] = mk_req(3'd0, 3'd3, 3'd7, BASE + 32'h10, 8'hFF, 64'h5555_6666_7777_8888, 1'b1);
        want_op  = '{3'd1, 3'd0, 3'd0, 3'd0};
        want_cor = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(tbl[i]);
            exp = model_apply(tbl[i]);
            total++;
            if (d_valid !== 1'b1 || d_denied !== 1'b1 || d_opcode !== want_op[i] ||
                d_corrupt !== want_cor[i] || d_data !== 64'd0 || d_source !== tbl[i].source) begin
                bad++;
                $display("FAIL deny[%0d]: got v=%b den=%b op=%0d cor=%b data=%h want 1/1/%0d/%b/0",
                         i, d_valid, d_denied, d_opcode, d_corrupt, d_data, want_op[i], want_cor[i]);
            end
            $display("txn deny[%0d] op=%0d addr=%h d_op=%0d den=%b", i, tbl[i].opcode, tbl[i].addr,
                     d_opcode, d_denied);
        end
        for (int w = 0; w < 3; w++) begin
            r = mk_req(3'd4, 3'd3, 3'd0, BASE + 32'(w * 8), 8'h00, 64'd0, 1'b0);
            issue(r);
            exp = model_apply(r);
            total++;
            if (d_data !== exp.data || d_denied !== 1'b0) begin
                bad++;
                $display("FAIL deny_unchanged[%0d]: got %h want %h", w, d_data, exp.data);
            end
            $display("txn get addr=%h data=%h", r.addr, d_data);
        end
    endtask

    task automatic test_random;
        req_t        r;
        rsp_t        exp, obs;
        logic [2:0]  op, sz;
        logic [31:0] addr;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    op = 3'd4;
                2:       op = 3'd0;
                3:       op = 3'd1;
                4:       op = 3'd4;
                default: op = 3'($urandom_range(0, 7));
            endcase
            sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            addr = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                                               : BASE + 32'($urandom_range(0, DEPTH * 8 + 7));
            if (sz <= 3 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            r = mk_req(op, sz, 3'($urandom_range(0, 7)), addr, 8'($urandom),
                       {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
            issue(r);
            exp = model_apply(r);
            obs = {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
            total++;
            if (d_valid !== 1'b1 || obs !== exp) begin
                bad++;
                $display("FAIL random[%0d]: got v=%b %h want v=1 %h", n, d_valid, obs, exp);
            end
            $display("txn rnd op=%0d sz=%0d addr=%h -> d_op=%0d den=%b data=%h",
                     op, sz, addr, d_opcode, d_denied, d_data);
        end
    endtask

    task automatic test_back_to_back;
        req_t r;
        rsp_t exp, obs;
        int   w;
        w = 0;
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0) begin
                w = $urandom_range(0, DEPTH - 1);
                r = mk_req(3'd1, 3'd3, 3'(k), BASE + 32'(w * 8), 8'($urandom),
                           {$urandom, $urandom}, 1'b0);
            end else begin
                r = mk_req(3'd4, 3'd3, 3'(k), BASE + 32'(w * 8), 8'h00, 64'd0, 1'b0);
            end
            drive_req(r);
            @(posedge clock);
            #1;
            exp = model_apply(r);
            obs = {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
            total++;
            if (d_valid !== 1'b1 || a_ready !== 1'b1 || obs !== exp) begin
                bad++;
                $display("FAIL b2b[%0d]: got v=%b rdy=%b %h want 1/1 %h", k, d_valid, a_ready, obs, exp);
            end
            $display("txn b2b op=%0d addr=%h data=%h", r.opcode, r.addr, d_data);
        end
        a_valid = 1'b0;
        @(posedge clock);
        #1;
        total++;
        if (d_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: got d_valid=%b want 0", d_valid);
        end
    endtask

    task automatic test_backpressure;
        req_t reqs [4];
        rsp_t exp_q [$];
        rsp_t exp, obs;
        for (int i = 0; i < 4; i++) begin
            reqs[i] = mk_req(3'd4, 3'd3, 3'(i + 1), BASE + 32'($urandom_range(0, DEPTH - 1) * 8),
                             8'hFF, 64'd0, 1'b0);
        end
        d_ready = 1'b0;
        drive_req(reqs[0]);
        @(posedge clock);
        #1;
        exp_q.push_back(model_apply(reqs[0]));
        drive_req(reqs[1]);
        for (int c = 0; c < 4; c++) begin
            obs = {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
            total++;
            if (d_valid !== 1'b1 || a_ready !== 1'b0 || obs !== exp_q[0]) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b %h want 1/0 %h",
                         c, d_valid, a_ready, obs, exp_q[0]);
            end
            $display("txn bp_hold cycle=%0d src=%0d", c, d_source);
            @(posedge clock);
            #1;
        end
        d_ready = 1'b1;
        #1;
        total++;
        if (a_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got a_ready=%b want 1", a_ready);
        end
        for (int k = 1; k < 4; k++) begin
            @(posedge clock);
            #1;
            void'(exp_q.pop_front());
            exp_q.push_back(model_apply(reqs[k]));
            if (k < 3) drive_req(reqs[k + 1]);
            else a_valid = 1'b0;
            exp = exp_q[0];
            obs = {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
            total++;
            if (d_valid !== 1'b1 || obs !== exp) begin
                bad++;
                $display("FAIL bp_stream[%0d]: got v=%b %h want v=1 %h", k, d_valid, obs, exp);
            end
            $display("txn bp_stream src=%0d data=%h", d_source, d_data);
        end
        @(posedge clock);
        #1;
        total++;
        if (d_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: got d_valid=%b want 0", d_valid);
        end
    endtask

    task automatic test_reset_mid;
        req_t r;
        rsp_t exp, obs;
        d_ready = 1'b0;
        r = mk_req(3'd4, 3'd3, 3'd3, BASE + 32'h10, 8'hFF, 64'd0, 1'b0);
        issue(r);
        exp = model_apply(r);
        total++;
        if (d_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pending: got d_valid=%b want 1", d_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        obs = {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
        total++;
        if (d_valid !== 1'b0 || a_ready !== 1'b1 || obs !== '0) begin
            bad++;
            $display("FAIL rst_mid_async: got v=%b rdy=%b %h want 0/1 0", d_valid, a_ready, obs);
        end
        $display("txn reset_mid d_valid=%b", d_valid);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        d_ready = 1'b1;
        r = mk_req(3'd4, 3'd3, 3'd6, BASE + 32'h10, 8'h00, 64'd0, 1'b0);
        issue(r);
        exp = model_apply(r);
        obs = {d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
        total++;
        if (d_valid !== 1'b1 || obs !== exp) begin
            bad++;
            $display("FAIL rst_mid_first_get: got v=%b %h want v=1 %h", d_valid, obs, exp);
        end
        $display("txn get after reset src=%0d data=%h", d_source, d_data);
    endtask

    initial begin
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 3'd0;
        a_source  = 3'd0;
        a_address = 32'd0;
        a_mask    = 8'd0;
        a_data    = 64'd0;
        a_corrupt = 1'b0;
        d_ready   = 1'b0;
        reset_n   = 1'b0;
        test_reset();
        test_fill();
        test_write_read();
        test_partial();
        test_denials();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
